// File: rtl/irq_arbiter.sv
// PLIC-lite interrupt arbiter: per-source pending/in-service gateways, priority/threshold
// arbitration and a word-addressed claim/complete config port driving mip_external_o.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               cfg_we_i,
  input  logic               cfg_re_i,
  input  logic [4:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               mip_external_o
);

  localparam logic [4:0] ADDR_ENABLE    = 5'h00;
  localparam logic [4:0] ADDR_THRESHOLD = 5'h01;
  localparam logic [4:0] ADDR_PENDING   = 5'h02;
  localparam logic [4:0] ADDR_CLAIM     = 5'h03;
  localparam logic [4:0] ADDR_PRIO_BASE = 5'h10;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_IN_SERVICE
  } gw_state_e;

  gw_state_e           gw_q [NUM_SRC];
  logic [NUM_SRC-1:0]  enable_q;
  logic [PRIO_W-1:0]   threshold_q;
  logic [PRIO_W-1:0]   prio_q [NUM_SRC];
  logic [ID_W-1:0]     best_id_q;
  logic                mip_q;
  logic [31:0]         rdata_q;

  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  claim_hit;
  logic [NUM_SRC-1:0]  complete_hit;
  logic [ID_W-1:0]     best_id;
  logic [PRIO_W-1:0]   best_prio;
  logic [31:0]         rdata_next;
  logic                claim_rd;
  logic                complete_wr;

  // Only the low bits of the write bus carry data; the rest are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_i;

  assign claim_rd    = cfg_re_i && (cfg_addr_i == ADDR_CLAIM);
  assign complete_wr = cfg_we_i && (cfg_addr_i == ADDR_CLAIM);

  // Strict '>' while scanning upward keeps the lowest id on equal priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pending   = '0;
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pending[i]  = (gw_q[i] == GW_PENDING);
      eligible[i] = pending[i] && enable_q[i] && (prio_q[i] > threshold_q);
      if (eligible[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  // Claim uses the registered winner; complete only releases a gateway that is in service.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_hit[i]    = claim_rd && (best_id_q == ID_W'(i + 1)) && (gw_q[i] == GW_PENDING);
      complete_hit[i] = complete_wr && (cfg_wdata_i[ID_W-1:0] == ID_W'(i + 1)) &&
                        (gw_q[i] == GW_IN_SERVICE);
    end
  end

  always_comb begin
    rdata_next = '0;
    case (cfg_addr_i)
      ADDR_ENABLE:    rdata_next[NUM_SRC-1:0] = enable_q;
      ADDR_THRESHOLD: rdata_next[PRIO_W-1:0]  = threshold_q;
      ADDR_PENDING:   rdata_next[NUM_SRC-1:0] = pending;
      ADDR_CLAIM:     rdata_next[ID_W-1:0]    = best_id_q;
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (cfg_addr_i == ADDR_PRIO_BASE + 5'(i)) rdata_next[PRIO_W-1:0] = prio_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    if (rst_i) begin
      // NOTE: the priority array is software-visible and must read 0 after reset, so it is reset explicitly.
      for (int i = 0; i < NUM_SRC; i++) begin
        gw_q[i]   <= GW_IDLE;
        prio_q[i] <= '0;
      end
      enable_q    <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
      mip_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        case (gw_q[i])
          GW_IDLE:       if (irq_src_i[i])    gw_q[i] <= GW_PENDING;
          GW_PENDING:    if (claim_hit[i])    gw_q[i] <= GW_IN_SERVICE;
          GW_IN_SERVICE: if (complete_hit[i]) gw_q[i] <= GW_IDLE;
          default:                            gw_q[i] <= GW_IDLE;
        endcase
      end

      if (cfg_we_i) begin
        case (cfg_addr_i)
          ADDR_ENABLE:    enable_q    <= cfg_wdata_i[NUM_SRC-1:0];
          ADDR_THRESHOLD: threshold_q <= cfg_wdata_i[PRIO_W-1:0];
          default: begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (cfg_addr_i == ADDR_PRIO_BASE + 5'(i)) prio_q[i] <= cfg_wdata_i[PRIO_W-1:0];
            end
          end
        endcase
      end

      best_id_q <= best_id;
      mip_q     <= (best_id != '0);
      if (cfg_re_i) rdata_q <= rdata_next;
    end
  end

  assign cfg_rdata_o    = rdata_q;
  assign mip_external_o = mip_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized traffic,
// all compared against a rule-level reference model of gateways and arbitration.
module tb_irq_arbiter;

  localparam int NUM = 8;
  localparam int S_IDLE = 0, S_PEND = 1, S_INSVC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mip;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, ids 1..NUM.
  int          st     [NUM+1];
  int          m_prio [NUM+1];
  logic [7:0]  m_en;
  int          m_thr;
  int          m_best;
  logic        m_mip;
  logic [31:0] m_rdata;

  irq_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_src_i     (src),
    .cfg_we_i      (we),
    .cfg_re_i      (re),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .cfg_rdata_o   (rdata),
    .mip_external_o(mip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Highest priority level first; within a level, the lowest pending enabled id wins.
  function automatic int model_winner();
    int w = 0;
    for (int p = 7; p > m_thr; p--)
      for (int id = 1; id <= NUM; id++)
        if (w == 0 && st[id] == S_PEND && m_en[id-1] && m_prio[id] == p) w = id;
    return w;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v = '0;
    if (a == 0) v = 32'(m_en);
    else if (a == 1) v = 32'(m_thr);
    else if (a == 2) begin
      for (int id = 1; id <= NUM; id++) if (st[id] == S_PEND) v[id-1] = 1'b1;
    end
    else if (a == 3) v = 32'(m_best);
    else if (a >= 16 && a < 16 + NUM) v = 32'(m_prio[a-15]);
    return v;
  endfunction

  // Advance model and DUT by one clock edge, then compare.
  task automatic tick();
    int old [NUM+1];
    int nb;
    int cid;
    logic [31:0] rv;
    if (rst) begin
      for (int id = 0; id <= NUM; id++) begin
        st[id] = S_IDLE;
        m_prio[id] = 0;
      end
      m_en = '0; m_thr = 0; m_best = 0; m_mip = 1'b0; m_rdata = '0;
    end else begin
      nb  = model_winner();
      rv  = model_read(int'(addr));
      old = st;
      if (re && addr == 5'd3 && m_best != 0 && old[m_best] == S_PEND) st[m_best] = S_INSVC;
      if (we && addr == 5'd3) begin
        cid = int'(wdata[3:0]);
        if (cid >= 1 && cid <= NUM && old[cid] == S_INSVC) st[cid] = S_IDLE;
      end
      for (int id = 1; id <= NUM; id++)
        if (old[id] == S_IDLE && src[id-1]) st[id] = S_PEND;
      if (we) begin
        if (addr == 5'd0) m_en = wdata[7:0];
        else if (addr == 5'd1) m_thr = int'(wdata[2:0]);
        else if (addr >= 5'd16 && int'(addr) < 16 + NUM) m_prio[int'(addr) - 15] = int'(wdata[2:0]);
      end
      m_best = nb;
      m_mip  = (nb != 0);
      if (re) m_rdata = rv;
    end
    @(posedge clk);
    #1;
    check("mip", {31'b0, mip}, {31'b0, m_mip});
    if (re || rst) check("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1; addr = 5'(a); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    re = 1'b1; addr = 5'(a);
    tick();
    v = rdata;
    re = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int addrs [16] = '{0, 1, 2, 3, 3, 3, 16, 17, 18, 19, 20, 21, 22, 23, 4, 31};

    // Reset held two cycles with every source asserted.
    rst = 1'b1; src = 8'hFF;
    tick(); tick();
    check("rst_mip", {31'b0, mip}, 32'd0);
    rst = 1'b0; src = '0;
    foreach (addrs[i]) begin
      if (addrs[i] != 3) begin
        rd(addrs[i], v);
        check("rst_read", v, 32'd0);
      end
    end
    rd(3, v); check("rst_claim", v, 32'd0);

    // Single source, id 3.
    wr(16 + 2, 2); wr(0, 32'h04); wr(1, 0);
    src = 8'h04;
    tick(); check("single_mip_n", {31'b0, mip}, 32'd0);
    tick(); check("single_mip_n1", {31'b0, mip}, 32'd1);
    rd(3, v); check("single_claim", v, 32'd3);
    tick(); check("single_mip_drop", {31'b0, mip}, 32'd0);
    src = '0;
    wr(3, 3);
    rd(2, v); check("single_pending", v, 32'd0);
    check("single_mip_after", {31'b0, mip}, 32'd0);

    // Priority order with a tie between ids 2 and 5.
    wr(16 + 1, 4); wr(16 + 4, 4); wr(16 + 6, 6); wr(0, 32'hFF);
    src = 8'h52;
    tick(); src = '0; tick();
    rd(3, v); check("order_1", v, 32'd7); tick();
    rd(3, v); check("order_2", v, 32'd2); tick();
    rd(3, v); check("order_3", v, 32'd5); tick();
    rd(3, v); check("order_4", v, 32'd0);
    wr(3, 7); wr(3, 2); wr(3, 5);

    // Threshold equal to priority masks; lowering it unmasks one edge after the write edge.
    wr(0, 32'h01); wr(16, 3); wr(1, 3);
    src = 8'h01; tick(); src = '0; tick(); tick();
    check("thr_masked", {31'b0, mip}, 32'd0);
    wr(1, 2);
    check("thr_write_edge", {31'b0, mip}, 32'd0);
    tick(); check("thr_unmasked", {31'b0, mip}, 32'd1);
    rd(3, v); check("thr_claim", v, 32'd1);
    tick(); wr(3, 1); wr(1, 0);

    // Level re-pend: id 4 held high through complete.
    wr(16 + 3, 5); wr(0, 32'h08);
    src = 8'h08;
    tick(); tick(); check("repend_mip", {31'b0, mip}, 32'd1);
    rd(3, v); check("repend_claim", v, 32'd4);
    tick(); wr(3, 4);
    tick(); check("repend_mip_gap", {31'b0, mip}, 32'd0);
    rd(2, v); check("repend_pending", v, 32'h08);
    check("repend_mip_back", {31'b0, mip}, 32'd1);
    src = '0;
    rd(3, v); check("repend_claim2", v, 32'd4);
    tick(); wr(3, 4); tick();

    // Illegal completes leave state untouched; reset clears in-service state.
    wr(16 + 5, 3); wr(0, 32'h28);
    src = 8'h28; tick(); src = '0; tick();
    rd(3, v); check("illegal_claim", v, 32'd4);
    tick();
    wr(3, 0); wr(3, 9); wr(3, 6);
    rd(2, v); check("illegal_pending", v, 32'h20);
    check("illegal_mip", {31'b0, mip}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    rd(2, v); check("rst_svc_pending", v, 32'd0);
    rd(3, v); check("rst_svc_claim", v, 32'd0);
    check("rst_svc_mip", {31'b0, mip}, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      src   = 8'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 2) == 0);
      addr  = 5'(addrs[$urandom_range(0, 15)]);
      wdata = (addr == 5'd3) ? 32'($urandom_range(0, 15)) : $urandom;
      rst   = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0; re = 1'b0; src = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
